// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared types and width helpers for the pulse multiplier family
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // acc stays below period, so acc + MULT needs one bit beyond CNT_W + clog2(MULT)
  function automatic int ACC_W(input int cnt_w, input int mult);
    return cnt_w + $clog2(mult) + 1;
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// rtl/pulse_sync_edge.sv - 2-FF synchroniser followed by a registered rising-edge detector
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_d    <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync1      <= din;
      sync2      <= sync1;
      sync2_d    <= sync2;
      edge_pulse <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/pulse_multiplier.sv
// rtl/pulse_multiplier.sv - emits MULT evenly spaced strobes per measured input period
module pulse_multiplier
  import pulse_pkg::*;
#(
  parameter int MULT  = 4,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             pulse_out,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic             slip
);

  localparam int AW = ACC_W(CNT_W, MULT);
  localparam int EW = $clog2(MULT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   P_MIN   = (CNT_W+1)'(2 * MULT);

  logic             edge_pulse;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    acc;
  logic [EW-1:0]    emitted;
  logic [CNT_W:0]   p_meas;
  logic             p_ok;
  logic             sat;
  logic             gen_active;
  logic [AW-1:0]    acc_sum;
  logic [AW-1:0]    period_ext;

  pulse_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .din        (pulse_in),
    .edge_pulse (edge_pulse)
  );

  // An edge on a saturated count would give 2^CNT_W, which cannot be held in period
  assign p_meas     = {1'b0, cnt} + (CNT_W+1)'(1);
  assign p_ok       = (p_meas >= P_MIN) && (p_meas <= {1'b0, CNT_MAX});
  assign sat        = (cnt == CNT_MAX);
  assign gen_active = (state == RUN) && (emitted < EW'(MULT));
  assign period_ext = AW'(period);
  assign acc_sum    = acc + AW'(MULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      emitted   <= '0;
      period    <= '0;
      pulse_out <= 1'b0;
      locked    <= 1'b0;
      slip      <= 1'b0;
    end else begin
      pulse_out <= 1'b0;
      slip      <= 1'b0;

      if (edge_pulse) begin
        cnt <= '0;
      end else if (!sat) begin
        cnt <= cnt + CNT_W'(1);
      end

      // Edge beats both saturation and a generator pulse landing on the same cycle
      if (edge_pulse) begin
        if (state == IDLE) begin
          state <= MEASURE;
        end else begin
          slip <= gen_active;
          if (p_ok) begin
            state     <= RUN;
            locked    <= 1'b1;
            period    <= p_meas[CNT_W-1:0];
            acc       <= '0;
            emitted   <= EW'(1);
            pulse_out <= 1'b1;
          end else begin
            state  <= MEASURE;
            locked <= 1'b0;
          end
        end
      end else if (sat && state != IDLE) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else if (gen_active) begin
        if (acc_sum >= period_ext) begin
          acc       <= acc_sum - period_ext;
          pulse_out <= 1'b1;
          emitted   <= emitted + EW'(1);
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_multiplier.sv
// tb/tb_pulse_multiplier.sv - directed bench with an event-level reference model
module tb_pulse_multiplier;

  localparam int MULT  = 4;
  localparam int CNT_W = 8;
  localparam int MAXC  = 255;
  localparam int S_IDLE = 0;
  localparam int S_MEAS = 1;
  localparam int S_RUN  = 2;

  logic             clk;
  logic             rst;
  logic             pulse_in;
  logic             pulse_out;
  logic             locked;
  logic [CNT_W-1:0] period;
  logic             slip;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_q[$];
  int ptimes[$];
  int slip_cnt = 0;
  int last_rise = 0;

  int m_state = S_IDLE;
  int m_last = 0;
  int m_base = 0;
  int m_per = 0;
  int m_p = 0;
  bit m_edge = 0;
  bit m_pulse = 0;
  bit m_slip = 0;
  bit m_locked = 0;

  pulse_multiplier #(.MULT(MULT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse_in),
    .pulse_out (pulse_out),
    .locked    (locked),
    .period    (period),
    .slip      (slip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int emitted_before(input int t);
    int n = 0;
    for (int j = 0; j < MULT; j++)
      if (m_base + ceil_div(j * m_per, MULT) < t) n++;
    return n;
  endfunction

  function automatic int count_in(input int lo, input int hi);
    int n = 0;
    foreach (ptimes[i])
      if (ptimes[i] >= lo && ptimes[i] < hi) n++;
    return n;
  endfunction

  // Model: an edge is seen 4 cycles after the bench raises pulse_in; pulse j sits ceil(j*P/MULT) after it
  always @(posedge clk) begin
    cyc = cyc + 1;
    m_edge = 0;
    if (rise_q.size() > 0 && rise_q[0] + 4 == cyc) begin
      void'(rise_q.pop_front());
      m_edge = 1;
    end
    m_pulse = 0;
    m_slip = 0;
    if (rst) begin
      m_state = S_IDLE;
      m_per = 0;
      m_last = 0;
      m_base = 0;
      rise_q.delete();
    end else if (m_edge) begin
      if (m_state != S_IDLE) begin
        m_p = cyc - m_last;
        m_slip = (m_state == S_RUN) && (emitted_before(cyc) < MULT);
        if (m_p >= 2 * MULT && m_p <= MAXC) begin
          m_state = S_RUN;
          m_per = m_p;
          m_base = cyc;
          m_pulse = 1;
        end else begin
          m_state = S_MEAS;
        end
      end else begin
        m_state = S_MEAS;
      end
      m_last = cyc;
    end else if (m_state != S_IDLE && cyc - m_last > MAXC) begin
      m_state = S_IDLE;
    end else if (m_state == S_RUN) begin
      for (int j = 1; j < MULT; j++)
        if (cyc == m_base + ceil_div(j * m_per, MULT)) m_pulse = 1;
    end
    m_locked = (m_state == S_RUN);
  end

  always @(negedge clk) begin
    chk("pulse_out", 32'(pulse_out), 32'(m_pulse));
    chk("slip", 32'(slip), 32'(m_slip));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("period", 32'(period), 32'(m_per));
    if (pulse_out === 1'b1) ptimes.push_back(cyc);
    if (slip === 1'b1) slip_cnt++;
  end

  task automatic pw(input int gap);
    pulse_in = 1'b1;
    rise_q.push_back(cyc);
    last_rise = cyc;
    repeat (3) @(negedge clk);
    pulse_in = 1'b0;
    repeat (gap - 3) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_offsets(input string name, input int b, input int p,
                               input int o0, input int o1, input int o2, input int o3);
    int offs[4];
    offs = '{o0, o1, o2, o3};
    foreach (offs[i])
      chk($sformatf("%s_off%0d", name, offs[i]), count_in(b + offs[i], b + offs[i] + 1), 1);
    chk({name, "_count"}, count_in(b, b + p), MULT);
  endtask

  initial begin
    int r0, sl0, rr, a;
    rst = 1'b1;
    pulse_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pulse_out", 32'(pulse_out), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_slip", 32'(slip), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // steady lock at 40
    r0 = cyc;
    sl0 = slip_cnt;
    repeat (4) pw(40);
    chk("steady_locked", 32'(locked), 1);
    chk("steady_period", 32'(period), 40);
    chk("steady_first_edge_silent", count_in(r0, r0 + 44), 0);
    check_offsets("steady", r0 + 84, 40, 0, 10, 20, 30);
    chk("steady_slip", slip_cnt - sl0, 0);
    repeat (270) @(negedge clk);

    // fractional period 41
    r0 = cyc;
    repeat (3) pw(41);
    chk("frac_period", 32'(period), 41);
    check_offsets("frac", r0 + 45, 41, 0, 11, 21, 31);
    repeat (270) @(negedge clk);

    // speed-up 40 -> 25
    r0 = cyc;
    sl0 = slip_cnt;
    repeat (3) pw(40);
    repeat (3) pw(25);
    chk("speed_slip_count", slip_cnt - sl0, 1);
    chk("speed_dropped30", count_in(r0 + 154, r0 + 155), 0);
    chk("speed_kept20", count_in(r0 + 144, r0 + 145), 1);
    check_offsets("speed", r0 + 149, 25, 0, 7, 13, 19);
    chk("speed_period", 32'(period), 25);
    repeat (270) @(negedge clk);

    // too fast, then relock
    r0 = cyc;
    repeat (2) pw(40);
    repeat (4) pw(6);
    chk("fast_locked", 32'(locked), 0);
    repeat (3) pw(40);
    chk("fast_no_pulses", count_in(r0 + 90, r0 + 148), 0);
    chk("relock_locked", 32'(locked), 1);
    chk("relock_period", 32'(period), 40);

    // timeout from the lock above
    a = last_rise;
    wait_cyc(a + 259);
    chk("timeout_before", 32'(locked), 1);
    wait_cyc(a + 260);
    chk("timeout_after", 32'(locked), 0);
    r0 = cyc;
    pw(40);
    chk("timeout_next_edge_locked", 32'(locked), 0);
    chk("timeout_next_edge_pulses", count_in(r0, r0 + 40), 0);
    repeat (270) @(negedge clk);

    // reset in the middle of RUN, on the offset-10 pulse
    repeat (2) pw(40);
    rr = cyc;
    pulse_in = 1'b1;
    rise_q.push_back(cyc);
    repeat (3) @(negedge clk);
    pulse_in = 1'b0;
    wait_cyc(rr + 14);
    chk("rst_mid_pulse_before", 32'(pulse_out), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_pulse_out", 32'(pulse_out), 0);
    chk("rst_mid_locked", 32'(locked), 0);
    chk("rst_mid_period", 32'(period), 0);
    chk("rst_mid_slip", 32'(slip), 0);
    wait_cyc(rr + 40);
    a = cyc;
    repeat (2) pw(40);
    chk("rst_relock_silent", count_in(rr + 15, a + 44), 0);
    chk("rst_relock_locked", 32'(locked), 1);
    chk("rst_relock_period", 32'(period), 40);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
